// File: rtl/ddr3_seq_pkg.sv
// Shared types and defaults for the DDR3 burst sequencer and its read-credit counter.
package ddr3_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    localparam int BURST_BEATS    = 2;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 288;
    localparam int DEF_LEN_W      = 16;
    localparam int DEF_RD_CREDITS = 32;

endpackage

// File: rtl/ddr3_rd_credit_counter.sv
// Tracks read beats in flight: +BURST_BEATS per issued burst, -1 per returned beat,
// floored at zero with a sticky flag for beats nobody asked for.
module ddr3_rd_credit_counter
    import ddr3_seq_pkg::*;
#(
    parameter int RD_CREDITS = DEF_RD_CREDITS,
    parameter int CNT_W      = $clog2(RD_CREDITS + 1)
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic inc2_i,
    input  logic dec1_i,
    output logic room_o,
    output logic empty_o,
    output logic underflow_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             underflow_q, underflow_d;

    always_comb begin
        count_d     = count_q;
        underflow_d = underflow_q;
        // A return against an empty count is unexpected: keep the floor and flag it.
        if (dec1_i) begin
            if (count_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
        if (inc2_i) begin
            count_d = count_d + CNT_W'(BURST_BEATS);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign room_o      = ({1'b0, count_q} + (CNT_W + 1)'(BURST_BEATS)) <= (CNT_W + 1)'(RD_CREDITS);
    assign empty_o     = (count_q == '0);
    assign underflow_o = underflow_q;

endmodule

// File: rtl/ddr3_burst_sequencer.sv
// Turns (read/write, address, length) requests into 2-beat DDR3 UI bursts,
// throttling reads against a credit window and forwarding returned beats.
module ddr3_burst_sequencer
    import ddr3_seq_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int RD_CREDITS = DEF_RD_CREDITS
) (
    input  logic                ui_app_clk,
    input  logic                ui_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_read,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_len,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                done,
    output logic                rd_underflow,
    output logic [ADDR_W-1:0]   ui_addr,
    output logic                ui_cmd,
    output logic [DATA_W-1:0]   ui_wr_data,
    output logic [DATA_W/8-1:0] ui_wr_mask,
    output logic                ui_wr_en,
    input  logic                ui_cmd_ack,
    input  logic [DATA_W-1:0]   ui_rd_data,
    input  logic                ui_rd_valid
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              parity_q, parity_d;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              credit_room;
    logic              credit_empty;
    logic              last_burst;

    assign last_burst = (remaining_q == LEN_W'(1));

    ddr3_rd_credit_counter #(
        .RD_CREDITS (RD_CREDITS)
    ) u_credit (
        .clk_i       (ui_app_clk),
        .srst_i      (ui_rst),
        .inc2_i      (ui_wr_en && (state_q == READ)),
        .dec1_i      (ui_rd_valid),
        .room_o      (credit_room),
        .empty_o     (credit_empty),
        .underflow_o (rd_underflow)
    );

    always_ff @(posedge ui_app_clk) begin
        if (ui_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = req_read ? READ : WRITE;
                    end
                end
            end
            WRITE:   if (ui_wr_en && parity_q && last_burst) state_d = DONE;
            READ:    if (ui_wr_en && last_burst) state_d = DRAIN;
            // Wait until every beat has also left the output register.
            DRAIN:   if (credit_empty && !rd_valid_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (ui_rst) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        req_ready  = 1'b0;
        wr_ready   = 1'b0;
        ui_wr_en   = 1'b0;
        ui_cmd     = 1'b0;
        ui_addr    = '0;
        ui_wr_data = '0;
        busy       = 1'b0;
        done       = 1'b0;
        if (!ui_rst) begin
            case (state_q)
                IDLE:  req_ready = 1'b1;
                WRITE: begin
                    busy       = 1'b1;
                    wr_ready   = ui_cmd_ack;
                    ui_wr_en   = wr_valid && ui_cmd_ack;
                    ui_addr    = addr_q;
                    ui_wr_data = wr_data;
                end
                READ: begin
                    busy     = 1'b1;
                    ui_cmd   = 1'b1;
                    ui_wr_en = ui_cmd_ack && credit_room;
                    ui_addr  = addr_q;
                end
                DRAIN:   busy = 1'b1;
                DONE:    done = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        parity_d    = parity_q;
        if (state_q == IDLE && req_valid) begin
            addr_d      = req_addr;
            remaining_d = req_len;
            parity_d    = 1'b0;
        end else if (ui_wr_en) begin
            // A read issue is a whole burst; a write burst ends on its odd beat.
            if (state_q == READ || parity_q) begin
                addr_d      = addr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
            end
            if (state_q == WRITE) begin
                parity_d = ~parity_q;
            end
        end
    end

    always_ff @(posedge ui_app_clk) begin
        if (ui_rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            parity_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            parity_q    <= parity_d;
            rd_valid_q  <= ui_rd_valid;
        end
        rd_data_q <= ui_rd_data;
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign ui_wr_mask = '0;

endmodule

// File: tb/tb_ddr3_burst_sequencer.sv
// Directed bench for ddr3_burst_sequencer with a queue-based reference model checked every cycle.
module tb_ddr3_burst_sequencer;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 288;
    localparam int LEN_W      = 16;
    localparam int RD_CREDITS = 32;

    localparam int M_IDLE  = 0;
    localparam int M_WR    = 1;
    localparam int M_RD    = 2;
    localparam int M_DRAIN = 3;
    localparam int M_DONE  = 4;

    logic                clk = 1'b0;
    logic                ui_rst = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_read = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [LEN_W-1:0]    req_len = '0;
    logic [DATA_W-1:0]   wr_data = '0;
    logic                wr_valid = 1'b0;
    logic                wr_ready;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;
    logic                busy;
    logic                done;
    logic                rd_underflow;
    logic [ADDR_W-1:0]   ui_addr;
    logic                ui_cmd;
    logic [DATA_W-1:0]   ui_wr_data;
    logic [DATA_W/8-1:0] ui_wr_mask;
    logic                ui_wr_en;
    logic                ui_cmd_ack = 1'b0;
    logic [DATA_W-1:0]   ui_rd_data = '0;
    logic                ui_rd_valid = 1'b0;

    ddr3_burst_sequencer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .RD_CREDITS (RD_CREDITS)
    ) dut (
        .ui_app_clk   (clk),
        .ui_rst       (ui_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_read     (req_read),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .done         (done),
        .rd_underflow (rd_underflow),
        .ui_addr      (ui_addr),
        .ui_cmd       (ui_cmd),
        .ui_wr_data   (ui_wr_data),
        .ui_wr_mask   (ui_wr_mask),
        .ui_wr_en     (ui_wr_en),
        .ui_cmd_ack   (ui_cmd_ack),
        .ui_rd_data   (ui_rd_data),
        .ui_rd_valid  (ui_rd_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: per-beat (write) or per-burst (read) address queue.
    int                m_ph = M_IDLE;
    int                m_out = 0;
    logic              m_uf = 1'b0;
    logic [ADDR_W-1:0] m_q[$];
    logic              prev_rst = 1'b1;
    logic              prev_rdv = 1'b0;
    logic [DATA_W-1:0] prev_rdd = '0;
    logic              e_en, e_rdv, e_rr, e_busy, e_done, e_wrr, e_cmd;
    int                nxt_out;
    logic [ADDR_W-1:0] a;

    // Observations used by the directed checks.
    logic [ADDR_W-1:0] obs_addr[$];
    int                done_cnt = 0;
    int                done_cyc = 0;
    int                last_issue_cyc = 0;
    int                cyc = 0;

    always @(negedge clk) begin
        e_rdv  = prev_rst ? 1'b0 : prev_rdv;
        e_rr   = !ui_rst && m_ph == M_IDLE;
        e_busy = !ui_rst && (m_ph == M_WR || m_ph == M_RD || m_ph == M_DRAIN);
        e_done = !ui_rst && m_ph == M_DONE;
        e_wrr  = !ui_rst && m_ph == M_WR && ui_cmd_ack;
        e_cmd  = !ui_rst && m_ph == M_RD;
        e_en   = 1'b0;
        if (!ui_rst && m_ph == M_WR) e_en = wr_valid && ui_cmd_ack;
        if (!ui_rst && m_ph == M_RD) e_en = ui_cmd_ack && (m_out + 2 <= RD_CREDITS);

        check("req_ready", DATA_W'(req_ready), DATA_W'(e_rr));
        check("busy", DATA_W'(busy), DATA_W'(e_busy));
        check("done", DATA_W'(done), DATA_W'(e_done));
        check("wr_ready", DATA_W'(wr_ready), DATA_W'(e_wrr));
        check("ui_wr_en", DATA_W'(ui_wr_en), DATA_W'(e_en));
        check("ui_cmd", DATA_W'(ui_cmd), DATA_W'(e_cmd));
        check("rd_valid", DATA_W'(rd_valid), DATA_W'(e_rdv));
        check("rd_underflow", DATA_W'(rd_underflow), DATA_W'(m_uf));
        check("ui_wr_mask", DATA_W'(ui_wr_mask), '0);
        if (e_rdv) check("rd_data", rd_data, prev_rdd);
        if (e_en && m_q.size() > 0) check("ui_addr", DATA_W'(ui_addr), DATA_W'(m_q[0]));
        if (e_en && m_ph == M_WR) check("ui_wr_data", ui_wr_data, wr_data);
        if (ui_rst) begin
            check("rst_ui_addr", DATA_W'(ui_addr), '0);
            check("rst_ui_wr_data", ui_wr_data, '0);
        end

        if (ui_wr_en) begin
            obs_addr.push_back(ui_addr);
            last_issue_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end

        prev_rst = ui_rst;
        prev_rdv = ui_rd_valid;
        prev_rdd = ui_rd_data;
        if (ui_rst) begin
            m_ph  = M_IDLE;
            m_out = 0;
            m_uf  = 1'b0;
            m_q.delete();
        end else begin
            nxt_out = m_out;
            if (ui_rd_valid) begin
                if (m_out == 0) m_uf = 1'b1;
                else nxt_out = nxt_out - 1;
            end
            if (e_en && m_ph == M_RD) nxt_out = nxt_out + 2;
            case (m_ph)
                M_IDLE: begin
                    if (req_valid) begin
                        for (int b = 0; b < int'(req_len); b++) begin
                            a = req_addr + ADDR_W'(b);
                            m_q.push_back(a);
                            if (!req_read) m_q.push_back(a);
                        end
                        if (req_len == '0) m_ph = M_DONE;
                        else m_ph = req_read ? M_RD : M_WR;
                    end
                end
                M_WR, M_RD: begin
                    if (e_en) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) m_ph = (m_ph == M_WR) ? M_DONE : M_DRAIN;
                    end
                end
                M_DRAIN: if (m_out == 0 && !e_rdv) m_ph = M_DONE;
                M_DONE:  m_ph = M_IDLE;
                default: m_ph = M_IDLE;
            endcase
            m_out = nxt_out;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_data = {9{$urandom}};
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        done_cnt = 0;
    endtask

    task automatic start_req(input logic rd, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        req_valid = 1'b1;
        req_read  = rd;
        req_addr  = addr;
        req_len   = len;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, DATA_W'(done_cnt), DATA_W'(1));
    endtask

    logic [ADDR_W-1:0] exp_w[6];
    logic [DATA_W-1:0] tag;
    int returned;
    int n;

    initial begin
        exp_w = '{32'h10, 32'h10, 32'h11, 32'h11, 32'h12, 32'h12};
        tick();
        check("reset_req_ready", DATA_W'(req_ready), '0);
        tick();
        ui_rst = 1'b0;
        tick();
        check("post_reset_req_ready", DATA_W'(req_ready), DATA_W'(1));
        check("post_reset_busy", DATA_W'(busy), '0);
        check("post_reset_underflow", DATA_W'(rd_underflow), '0);

        // Write, 3 bursts, continuous ack.
        wr_valid = 1'b1;
        ui_cmd_ack = 1'b1;
        clear_obs();
        start_req(1'b0, 32'h10, 16'd3);
        wait_done("wr1_done", 40);
        check("wr1_beats", DATA_W'(obs_addr.size()), DATA_W'(6));
        for (int i = 0; i < 6 && i < obs_addr.size(); i++)
            check("wr1_addr", DATA_W'(obs_addr[i]), DATA_W'(exp_w[i]));
        check("wr1_done_lat", DATA_W'(done_cyc - last_issue_cyc), DATA_W'(1));
        $display("[TB] write 3 bursts @0x10: %0d beats", obs_addr.size());
        tick();

        // Same write with ack withdrawn where beats 3-4 would go.
        clear_obs();
        start_req(1'b0, 32'h10, 16'd3);
        tick();
        tick();
        ui_cmd_ack = 1'b0;
        tick();
        tick();
        check("wr2_stalled_beats", DATA_W'(obs_addr.size()), DATA_W'(2));
        ui_cmd_ack = 1'b1;
        wait_done("wr2_done", 40);
        check("wr2_beats", DATA_W'(obs_addr.size()), DATA_W'(6));
        for (int i = 0; i < 6 && i < obs_addr.size(); i++)
            check("wr2_addr", DATA_W'(obs_addr[i]), DATA_W'(exp_w[i]));
        $display("[TB] write with ack stall: %0d beats", obs_addr.size());
        tick();

        // Read 20 bursts: credit stall at 16, then trickle returns.
        clear_obs();
        start_req(1'b1, 32'h100, 16'd20);
        for (int i = 0; i < 30; i++) tick();
        check("rd_stall_issues", DATA_W'(obs_addr.size()), DATA_W'(16));
        ui_rd_valid = 1'b1;
        tick();
        tick();
        ui_rd_valid = 1'b0;
        returned = 2;
        for (int i = 0; i < 5; i++) tick();
        check("rd_after2_issues", DATA_W'(obs_addr.size()), DATA_W'(17));
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            ui_rd_valid = (returned < 2 * obs_addr.size());
            if (ui_rd_valid) begin
                returned++;
                ui_rd_data = {9{$urandom}};
            end
            tick();
            n++;
        end
        ui_rd_valid = 1'b0;
        check("rd20_done", DATA_W'(done_cnt), DATA_W'(1));
        check("rd20_returned", DATA_W'(returned), DATA_W'(40));
        check("rd20_issues", DATA_W'(obs_addr.size()), DATA_W'(20));
        if (obs_addr.size() == 20) check("rd20_last_addr", DATA_W'(obs_addr[19]), DATA_W'(32'h113));
        check("rd20_underflow", DATA_W'(rd_underflow), '0);
        $display("[TB] read 20 bursts: %0d issues, %0d beats returned", obs_addr.size(), returned);
        tick();

        // Address wrap.
        clear_obs();
        start_req(1'b1, 32'hFFFF_FFFF, 16'd2);
        tick();
        tick();
        tick();
        check("wrap_issues", DATA_W'(obs_addr.size()), DATA_W'(2));
        if (obs_addr.size() == 2) begin
            check("wrap_addr0", DATA_W'(obs_addr[0]), DATA_W'(32'hFFFF_FFFF));
            check("wrap_addr1", DATA_W'(obs_addr[1]), '0);
        end
        ui_rd_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        ui_rd_valid = 1'b0;
        wait_done("wrap_done", 20);
        $display("[TB] read wrap @0xFFFFFFFF: %0d issues", obs_addr.size());
        tick();

        // Unexpected beat in IDLE.
        tag = DATA_W'(36'hABC_DEF_123);
        ui_rd_data = tag;
        ui_rd_valid = 1'b1;
        tick();
        ui_rd_valid = 1'b0;
        check("uf_rd_valid", DATA_W'(rd_valid), DATA_W'(1));
        check("uf_rd_data", rd_data, tag);
        check("uf_flag", DATA_W'(rd_underflow), DATA_W'(1));
        ui_rst = 1'b1;
        tick();
        ui_rst = 1'b0;
        check("uf_cleared", DATA_W'(rd_underflow), '0);
        $display("[TB] idle return: underflow flagged then cleared");
        tick();

        // Reset mid-read, then a zero-length request.
        clear_obs();
        start_req(1'b1, 32'h200, 16'd20);
        tick();
        tick();
        tick();
        ui_rst = 1'b1;
        #1;
        check("midrst_wr_en", DATA_W'(ui_wr_en), '0);
        check("midrst_req_ready", DATA_W'(req_ready), '0);
        tick();
        ui_rst = 1'b0;
        #1;
        check("midrst_busy", DATA_W'(busy), '0);
        check("midrst_no_done", DATA_W'(done_cnt), '0);
        ui_rd_valid = 1'b1;
        tick();
        ui_rd_valid = 1'b0;
        check("midrst_late_uf", DATA_W'(rd_underflow), DATA_W'(1));
        start_req(1'b0, 32'h0, 16'd0);
        check("len0_done", DATA_W'(done), DATA_W'(1));
        tick();
        check("len0_done_pulse", DATA_W'(done), '0);
        $display("[TB] mid-read reset then len=0: done_cnt=%0d", done_cnt);
        ui_rst = 1'b1;
        tick();
        ui_rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
